fnd_bcd_scan_driver: RTL

- Downstream consumer of the ripple-carry adder chain built from full adders: takes the binary sum word and drives a 4-digit common-anode FND (7-segment) display.
- Converts binary to packed BCD sequentially (shift-and-add-3, one bit per two cycles), latches the result, then time-multiplexes the four digits.
- Leading zeros are blanked; out-of-range inputs show "----".

---
 rtl/fnd_bcd_scan_driver.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/fnd_bcd_scan_driver.sv
// Binary-to-BCD converter (shift-and-add-3, one bit per two cycles) feeding a
// 4-digit common-anode 7-segment scanner with leading-zero blanking.
module fnd_bcd_scan_driver #(
  parameter int DATA_W   = 14,
  parameter int SCAN_DIV = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_load,
  output logic              o_busy,
  output logic [15:0]       o_bcd,
  output logic              o_ovf,
  output logic [3:0]        o_fnd_com,
  output logic [7:0]        o_fnd_font
);

  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(DATA_W);
  localparam logic [SCAN_W-1:0] SCAN_TC   = SCAN_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, ADJ, SHF, DONE} state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] bin_q, bin_next;
  logic [15:0]       scr_q, scr_next;
  logic [CNT_W-1:0]  cnt_q, cnt_next;
  logic              ovf_cap, ovf_cap_next;
  logic              busy_next;
  logic [15:0]       bcd_next;
  logic              ovf_next;

  // Conversion FSM: next-state and datapath
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next   = state;
    bin_next     = bin_q;
    scr_next     = scr_q;
    cnt_next     = cnt_q;
    ovf_cap_next = ovf_cap;
    busy_next    = o_busy;
    bcd_next     = o_bcd;
    ovf_next     = o_ovf;

    unique case (state)
      IDLE: begin
        if (i_load) begin
          bin_next     = i_data;
          scr_next     = 16'h0000;
          cnt_next     = '0;
          ovf_cap_next = (32'(i_data) > 32'd9999);
          busy_next    = 1'b1;
          state_next   = ADJ;
        end
      end
      ADJ: begin
        for (int i = 0; i < 4; i++) begin
          if (scr_q[4*i +: 4] >= 4'd5) scr_next[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
        end
        state_next = SHF;
      end
      SHF: begin
        {scr_next, bin_next} = {scr_q, bin_q} << 1;
        cnt_next   = cnt_q + CNT_W'(1);
        state_next = (cnt_next == LAST_ITER) ? DONE : ADJ;
      end
      DONE: begin
        // Out-of-range values never reach the display as digits; show dashes instead.
        bcd_next   = ovf_cap ? 16'h0000 : scr_q;
        ovf_next   = ovf_cap;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: reset is synchronous and active-high, so it lives inside the clocked block's if.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state   <= IDLE;
      bin_q   <= '0;
      scr_q   <= 16'h0000;
      cnt_q   <= '0;
      ovf_cap <= 1'b0;
      o_busy  <= 1'b0;
      o_bcd   <= 16'h0000;
      o_ovf   <= 1'b0;
    end else begin
      state   <= state_next;
      bin_q   <= bin_next;
      scr_q   <= scr_next;
      cnt_q   <= cnt_next;
      ovf_cap <= ovf_cap_next;
      o_busy  <= busy_next;
      o_bcd   <= bcd_next;
      o_ovf   <= ovf_next;
    end
  end

  // Digit scanner, free-running and independent of the converter
  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        idx, idx_next;
  logic              scan_tc;
  logic [3:0]        digit;
  logic              blank;
  logic [7:0]        font_next;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    unique case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  assign scan_tc  = (scan_cnt == SCAN_TC);
  assign idx_next = scan_tc ? idx + 2'd1 : idx;
  assign digit    = o_bcd[4*idx_next +: 4];

  // A digit is blank when it and every higher digit are zero; ones is never blank.
  always_comb begin
    blank = 1'b0;
    unique case (idx_next)
      2'd1:    blank = (o_bcd[15:4]  == 12'h000);
      2'd2:    blank = (o_bcd[15:8]  == 8'h00);
      2'd3:    blank = (o_bcd[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
    if (o_ovf)      font_next = 8'hBF;
    else if (blank) font_next = 8'hFF;
    else            font_next = seg7(digit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt   <= '0;
      idx        <= 2'd0;
      o_fnd_com  <= 4'b1110;
      o_fnd_font <= 8'hC0;
    end else begin
      scan_cnt   <= scan_tc ? '0 : scan_cnt + SCAN_W'(1);
      idx        <= idx_next;
      o_fnd_com  <= ~(4'b0001 << idx_next);
      o_fnd_font <= font_next;
    end
  end

endmodule
